// File: rtl/dev_req_queue.sv
// Host request FIFO feeding a single-outstanding master port, with a held response register.
// Optional feature macro REQ_QUEUE_TIMEOUT_EN: bounded device wait that completes the request with r_err=1.
module dev_req_queue #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_WIDTH-1:0]  h_wdata,
  input  logic [ADDR_WIDTH-1:0]  h_addr,
  input  logic                   h_mode,
  input  logic                   h_valid,
  output logic                   h_ready,
  output logic [DATA_WIDTH-1:0]  r_data,
  output logic                   r_mode,
  output logic                   r_err,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [DATA_WIDTH-1:0]  dwdata,
  output logic [ADDR_WIDTH-1:0]  daddr,
  output logic                   dmode,
  output logic                   dvalid,
  input  logic                   dready,
  input  logic [DATA_WIDTH-1:0]  drdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [EW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  state_t                state_q, state_d;
  logic                  push_s, pop_s, timeout_s;
  logic [EW-1:0]         head_s;
  logic                  dvalid_q, dvalid_d, dmode_q, dmode_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d, r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d, r_mode_q, r_mode_d, r_err_q, r_err_d;

  // A full queue refuses pushes even if a pop happens the same cycle.
  assign h_ready = (count_q < CW'(DEPTH));
  assign push_s  = h_valid && h_ready;
  assign pop_s   = (state_q == IDLE) && (count_q != '0) && !r_valid_q;
  assign head_s  = mem_q[rd_ptr_q];

  // Request storage; payload needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {h_mode, h_addr, h_wdata};
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef REQ_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          waiting_s;

  assign waiting_s = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign timeout_s = waiting_s && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Wait-time counter; zero outside the wait states so WAIT_BUSY always starts from 0.
  always_comb begin
    if (waiting_s) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end
  end

  // Wait-time counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Transaction FSM next-state and registered output values.
  always_comb begin
    state_d   = state_q;
    dvalid_d  = dvalid_q;
    dmode_d   = dmode_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    r_mode_d  = r_mode_q;
    r_data_d  = r_data_q;
    r_err_d   = r_err_q;
    if (r_valid_q && r_ready) begin
      r_valid_d = 1'b0;
    end else begin
      r_valid_d = r_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d                      = ISSUE;
          dvalid_d                     = 1'b1;
          {dmode_d, daddr_d, dwdata_d} = head_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (dready) begin
          state_d  = WAIT_BUSY;
          dvalid_d = 1'b0;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_BUSY: begin
        if (timeout_s) begin
          state_d   = IDLE;
          r_valid_d = 1'b1;
          r_mode_d  = dmode_q;
          r_data_d  = '0;
          r_err_d   = 1'b1;
        end else if (!dready) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (dready || timeout_s) begin
          state_d   = IDLE;
          r_valid_d = 1'b1;
          r_mode_d  = dmode_q;
          r_data_d  = (dready && !dmode_q) ? drdata : '0;
          r_err_d   = !dready;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d  = IDLE;
        dvalid_d = 1'b0;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      dvalid_q  <= 1'b0;
      dmode_q   <= 1'b0;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      r_valid_q <= 1'b0;
      r_mode_q  <= 1'b0;
      r_data_q  <= '0;
      r_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvalid_q  <= dvalid_d;
      dmode_q   <= dmode_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      r_valid_q <= r_valid_d;
      r_mode_q  <= r_mode_d;
      r_data_q  <= r_data_d;
      r_err_q   <= r_err_d;
    end
  end

  assign count   = count_q;
  assign dvalid  = dvalid_q;
  assign dmode   = dmode_q;
  assign daddr   = daddr_q;
  assign dwdata  = dwdata_q;
  assign r_valid = r_valid_q;
  assign r_mode  = r_mode_q;
  assign r_data  = r_data_q;
  assign r_err   = r_err_q;

endmodule
